bcu_tile_port: RTL and testbench
================================

BCU_TILE_PORT -- requirements
Module: bcu_tile_port

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 tile_ofs_cs, tile_attr_cs, tile_num_cs, scroll_cs, bcu_flip_cs  in  1 each  68K decoded selects; level, held for the whole bus cycle.
REQ-004 cpu_a  in  3  68K address bits [3:1]; scroll register index.
REQ-005 cpu_rw  in  1  1 = read, 0 = write.
REQ-006 cpu_dout  in  16  68K write data.
REQ-007 cpu_din  out  16  read data to 68K.
REQ-008 dtack_n  out  1  active-low acknowledge to 68K.
REQ-009 vram_addr  out  13  tile RAM word address: {tile_ofs[11:0], sel}; sel 0 = attr, 1 = num.
REQ-010 vram_we  out  1  one-cycle tile RAM write strobe.
REQ-011 vram_wdata  out  16  tile RAM write data.
REQ-012 vram_rdata  in  16  tile RAM read data; valid one clk after vram_addr.
REQ-013 layer_scroll  out  128  8 x 16-bit scroll registers; register n occupies bits [16n+15:16n].
REQ-014 bcu_flip  out  1  screen flip flag.

Function
REQ-015 Access start: rising edge of OR of the five selects (previous-cycle OR low, current high); in IDLE only.
REQ-016 Simultaneous selects: priority tile_ofs > tile_attr > tile_num > scroll > bcu_flip; only the winner is serviced.
REQ-017 States: IDLE, WRITE, RD_ADDR, RD_DATA, ACK.
REQ-018 IDLE -> WRITE on a start with cpu_rw=0; IDLE -> RD_ADDR on a start with cpu_rw=1.
REQ-019 WRITE (1 cycle) actions by select:
- tile_ofs: tile_ofs <= cpu_dout[11:0].
- tile_attr / tile_num: vram_we=1, vram_wdata=cpu_dout, vram_addr={tile_ofs, sel}.
- scroll: register cpu_a <= cpu_dout.
- bcu_flip: bcu_flip <= cpu_dout[0].
WRITE -> ACK next cycle.
REQ-020 RD_ADDR drives vram_addr for attr/num reads, then -> RD_DATA.
REQ-021 RD_DATA latches cpu_din, then -> ACK:
- tile_ofs: {4'b0, tile_ofs}.
- attr / num: vram_rdata.
- scroll: register cpu_a.
- bcu_flip: {15'b0, bcu_flip}.
REQ-022 ACK: dtack_n=0; hold until all five selects are low, then dtack_n=1 and -> IDLE.
REQ-023 Latency from start edge to dtack_n=0: write 2 clk; read 3 clk.
REQ-024 Selects that change or re-assert while not in IDLE are ignored; no queuing.
REQ-025 vram_we is high only in WRITE for attr/num, never otherwise.
REQ-026 tile_ofs does not auto-increment; tile_ofs write values above 0xFFF are truncated to 12 bits.
REQ-027 cpu_din holds its last value outside RD_DATA.

Reset
REQ-028 On reset, the following take these values, overriding any cycle in progress (mid-access reset abandons the access without ack):
- state = IDLE
- dtack_n = 1
- vram_we = 0
- tile_ofs = 0
- layer_scroll = 0
- bcu_flip = 0
- cpu_din = 0
- vram_addr = 0
- vram_wdata = 0
- select-edge history = 0

Configuration
REQ-029 Macro BCU_READBACK_EN.
- Defined: reads behave per REQ-020/021.
- Undefined: reads go IDLE -> ACK directly, cpu_din = 0x0000, read latency 1 clk, and vram_rdata is unused.
- Writes are identical in both builds.

Verification
REQ-030 Write 0x0123 to tile_ofs, then 0xBEEF to tile_attr -> vram_we is high for exactly 1 clk with vram_addr=0x0246 and vram_wdata=0xBEEF; dtack_n falls 2 clk after the select edge.
REQ-031 Read tile_num with tile_ofs=0x0123 and model rdata 0x5A5A at addr 0x0247 -> cpu_din=0x5A5A, dtack_n low 3 clk after edge (macro defined); cpu_din=0x0000 at 1 clk (undefined).
REQ-032 Write 0x01C0 to scroll with cpu_a=5 -> layer_scroll[95:80]=0x01C0 and all other bits unchanged; read back returns 0x01C0.
REQ-033 Hold tile_num_cs high 10 clk -> exactly one vram_we pulse; dtack_n stays low until the select drops, then rises the next clk.
REQ-034 tile_ofs_cs and tile_attr_cs asserted together with data 0x0FFF -> only tile_ofs=0xFFF is updated and there is no vram_we pulse.
REQ-035 Assert reset during RD_DATA -> next clk state=IDLE, dtack_n=1, tile_ofs=0, bcu_flip=0; a new access afterwards completes normally.

Source files
------------

// File: rtl/bcu_tile_port.sv
// bcu_tile_port: 68K-facing port for the BCU tile layer. Decodes the five
// chip selects into tile-offset, tile RAM, scroll and flip accesses and
// answers each bus cycle with a single DTACK.
// Build option: define BCU_READBACK_EN to enable real read data (tile RAM,
// tile offset, scroll, flip). Without it reads acknowledge after one clock
// with cpu_din = 0 and vram_rdata is ignored.
// Handshake: an access starts on the rising edge of the OR of the selects
// while idle; dtack_n stays low until every select is released, and the
// port returns to idle on the clock after release. Selects seen outside
// idle are ignored, never queued.
module bcu_tile_port (
  input  logic         clk,
  input  logic         reset,
  input  logic         tile_ofs_cs,
  input  logic         tile_attr_cs,
  input  logic         tile_num_cs,
  input  logic         scroll_cs,
  input  logic         bcu_flip_cs,
  input  logic [2:0]   cpu_a,
  input  logic         cpu_rw,
  input  logic [15:0]  cpu_dout,
  output logic [15:0]  cpu_din,
  output logic         dtack_n,
  output logic [12:0]  vram_addr,
  output logic         vram_we,
  output logic [15:0]  vram_wdata,
  input  logic [15:0]  vram_rdata,
  output logic [127:0] layer_scroll,
  output logic         bcu_flip,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    SEL_OFS    = 3'd0,
    SEL_ATTR   = 3'd1,
    SEL_NUM    = 3'd2,
    SEL_SCROLL = 3'd3,
    SEL_FLIP   = 3'd4
  } sel_t;

  state_t      state_q;
  sel_t        which_q;
  sel_t        win;
  logic [2:0]  a_q;
  logic        sel_prev_q;
  logic        sel_any;
  logic        start;
  logic [11:0] tile_ofs_q;
  logic [15:0] scroll_q [8];
  logic        flip_q;
  logic [15:0] cpu_din_q;
  logic        dtack_n_q;
  logic [12:0] vram_addr_q;
  logic        vram_we_q;
  logic [15:0] vram_wdata_q;

`ifndef BCU_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^vram_rdata;
`endif

  assign sel_any = tile_ofs_cs | tile_attr_cs | tile_num_cs | scroll_cs | bcu_flip_cs;
  assign start   = sel_any & ~sel_prev_q & (state_q == ST_IDLE);

  // Fixed-priority pick of the select that gets serviced.
  always_comb begin
    win = SEL_FLIP;
    if (tile_ofs_cs)       win = SEL_OFS;
    else if (tile_attr_cs) win = SEL_ATTR;
    else if (tile_num_cs)  win = SEL_NUM;
    else if (scroll_cs)    win = SEL_SCROLL;
  end

  // Access sequencer: edge detect, FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      which_q      <= SEL_OFS;
      a_q          <= 3'd0;
      sel_prev_q   <= 1'b0;
      tile_ofs_q   <= 12'd0;
      for (int i = 0; i < 8; i++) scroll_q[i] <= 16'd0;
      flip_q       <= 1'b0;
      cpu_din_q    <= 16'd0;
      dtack_n_q    <= 1'b1;
      vram_addr_q  <= 13'd0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= 16'd0;
    end else begin
      sel_prev_q <= sel_any;
      vram_we_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            which_q <= win;
            a_q     <= cpu_a;
            if (!cpu_rw) begin
              state_q <= ST_WRITE;
              // Tile RAM strobe is registered so it is high exactly during WRITE.
              if (win == SEL_ATTR || win == SEL_NUM) begin
                vram_we_q    <= 1'b1;
                vram_addr_q  <= {tile_ofs_q, win == SEL_NUM};
                vram_wdata_q <= cpu_dout;
              end
            end else begin
`ifdef BCU_READBACK_EN
              state_q <= ST_RD_ADDR;
              // Address goes out a cycle early so the RAM data is ready in RD_DATA.
              if (win == SEL_ATTR || win == SEL_NUM)
                vram_addr_q <= {tile_ofs_q, win == SEL_NUM};
`else
              state_q   <= ST_ACK;
              dtack_n_q <= 1'b0;
              cpu_din_q <= 16'd0;
`endif
            end
          end
        end
        ST_WRITE: begin
          case (which_q)
            SEL_OFS:    tile_ofs_q    <= cpu_dout[11:0];
            SEL_SCROLL: scroll_q[a_q] <= cpu_dout;
            SEL_FLIP:   flip_q        <= cpu_dout[0];
            default:    ;
          endcase
          state_q   <= ST_ACK;
          dtack_n_q <= 1'b0;
        end
`ifdef BCU_READBACK_EN
        ST_RD_ADDR: begin
          state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          case (which_q)
            SEL_OFS:    cpu_din_q <= {4'b0, tile_ofs_q};
            SEL_SCROLL: cpu_din_q <= scroll_q[a_q];
            SEL_FLIP:   cpu_din_q <= {15'b0, flip_q};
            default:    cpu_din_q <= vram_rdata;
          endcase
          state_q   <= ST_ACK;
          dtack_n_q <= 1'b0;
        end
`endif
        ST_ACK: begin
          if (!sel_any) begin
            dtack_n_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Flatten the scroll register file onto the output bus.
  always_comb begin
    layer_scroll = '0;
    for (int i = 0; i < 8; i++) layer_scroll[16*i +: 16] = scroll_q[i];
  end

  assign cpu_din    = cpu_din_q;
  assign dtack_n    = dtack_n_q;
  assign vram_addr  = vram_addr_q;
  assign vram_we    = vram_we_q;
  assign vram_wdata = vram_wdata_q;
  assign bcu_flip   = flip_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bcu_tile_port.sv
// tb_bcu_tile_port: directed bench for bcu_tile_port with a small tile RAM
// model. Read expectations follow BCU_READBACK_EN when it is defined.
module tb_bcu_tile_port;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   cs_v;   // {ofs, attr, num, scroll, flip}
  logic [2:0]   cpu_a;
  logic         cpu_rw;
  logic [15:0]  cpu_dout;
  logic [15:0]  cpu_din;
  logic         dtack_n;
  logic [12:0]  vram_addr;
  logic         vram_we;
  logic [15:0]  vram_wdata;
  logic [15:0]  vram_rdata;
  logic [127:0] layer_scroll;
  logic         bcu_flip;
  logic [2:0]   dbg_state;

  localparam logic [4:0] CS_OFS = 5'b10000, CS_ATTR = 5'b01000, CS_NUM = 5'b00100,
                         CS_SCR = 5'b00010, CS_FLIP = 5'b00001;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [12:0] we_addr;
  logic [15:0] we_data;
  logic [15:0] mem [0:8191];

  bcu_tile_port dut (
    .clk(clk), .reset(reset),
    .tile_ofs_cs(cs_v[4]), .tile_attr_cs(cs_v[3]), .tile_num_cs(cs_v[2]),
    .scroll_cs(cs_v[1]), .bcu_flip_cs(cs_v[0]),
    .cpu_a(cpu_a), .cpu_rw(cpu_rw), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .dtack_n(dtack_n), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .layer_scroll(layer_scroll), .bcu_flip(bcu_flip), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Tile RAM model: synchronous read, data valid one clock after the address.
  always @(posedge clk) begin
    if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= vram_addr;
      we_data <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete bus cycle; lat counts clocks from the select edge to dtack_n low.
  task automatic access(input logic [4:0] cs, input logic rw, input logic [2:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] din);
    @(negedge clk);
    cs_v = cs; cpu_rw = rw; cpu_a = a; cpu_dout = d;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!dtack_n) break;
    end
    din = cpu_din;
    @(negedge clk);
    cs_v = 5'b0;
    @(posedge clk); #1;
    check("dtack_release", dtack_n, 1'b1);
  endtask

  int          lat;
  int          we0;
  logic [15:0] din;
  int          rd_lat;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[13'h0247] = 16'h5A5A;
`ifdef BCU_READBACK_EN
    rd_lat = 3;
`else
    rd_lat = 1;
`endif
    reset = 1'b1; cs_v = 5'b0; cpu_a = 3'd0; cpu_rw = 1'b1; cpu_dout = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, 3'd0);
    check("rst_dtack", dtack_n, 1'b1);
    check("rst_we", vram_we, 1'b0);
    check("rst_din", cpu_din, 16'h0);
    check("rst_vaddr", vram_addr, 13'h0);
    check("rst_scroll", layer_scroll, 128'h0);
    check("rst_flip", bcu_flip, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    // Tile offset then attribute write.
    access(CS_OFS, 1'b0, 3'd0, 16'h0123, lat, din);
    check("ofs_wr_lat", lat, 2);
    we0 = we_cnt;
    access(CS_ATTR, 1'b0, 3'd0, 16'hBEEF, lat, din);
    check("attr_wr_lat", lat, 2);
    check("attr_we_cnt", we_cnt - we0, 1);
    check("attr_we_addr", we_addr, 13'h0246);
    check("attr_we_data", we_data, 16'hBEEF);

    // Tile number read from the RAM model.
    access(CS_NUM, 1'b1, 3'd0, 16'h0, lat, din);
    check("num_rd_lat", lat, rd_lat);
`ifdef BCU_READBACK_EN
    check("num_rd_data", din, 16'h5A5A);
    access(CS_OFS, 1'b1, 3'd0, 16'h0, lat, din);
    check("ofs_rd_data", din, 16'h0123);
`else
    check("num_rd_data", din, 16'h0000);
`endif

    // Scroll register 5.
    access(CS_SCR, 1'b0, 3'd5, 16'h01C0, lat, din);
    check("scr_wr_lat", lat, 2);
    check("scr_bus", layer_scroll, 128'h01C0 << 80);
`ifdef BCU_READBACK_EN
    access(CS_SCR, 1'b1, 3'd5, 16'h0, lat, din);
    check("scr_rd_data", din, 16'h01C0);
`endif

    // Flip flag takes bit 0 only.
    access(CS_FLIP, 1'b0, 3'd0, 16'hFFFF, lat, din);
    check("flip_set", bcu_flip, 1'b1);
`ifdef BCU_READBACK_EN
    access(CS_FLIP, 1'b1, 3'd0, 16'h0, lat, din);
    check("flip_rd_data", din, 16'h0001);
`endif

    // Select held 10 clocks: one pulse, dtack held until release.
    we0 = we_cnt;
    @(negedge clk);
    cs_v = CS_NUM; cpu_rw = 1'b0; cpu_dout = 16'h1234;
    repeat (10) @(posedge clk);
    #1;
    check("hold_dtack_low", dtack_n, 1'b0);
    @(negedge clk);
    cs_v = 5'b0;
    @(posedge clk); #1;
    check("hold_dtack_rise", dtack_n, 1'b1);
    check("hold_we_cnt", we_cnt - we0, 1);
    check("hold_we_addr", we_addr, 13'h0247);

    // Simultaneous ofs+attr: only the offset is written.
    we0 = we_cnt;
    access(CS_OFS | CS_ATTR, 1'b0, 3'd0, 16'h0FFF, lat, din);
    check("prio_no_we", we_cnt - we0, 0);
    access(CS_ATTR, 1'b0, 3'd0, 16'hA001, lat, din);
    check("prio_ofs_addr", we_addr, 13'h1FFE);

    // Offset truncated to 12 bits.
    access(CS_OFS, 1'b0, 3'd0, 16'hF123, lat, din);
    access(CS_NUM, 1'b0, 3'd0, 16'hC0DE, lat, din);
    check("trunc_addr", we_addr, 13'h0247);
    check("trunc_data", we_data, 16'hC0DE);

    // Reset in the middle of a read.
    @(negedge clk);
    cs_v = CS_NUM; cpu_rw = 1'b1;
    repeat (rd_lat == 3 ? 2 : 1) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_state", dbg_state, 3'd0);
    check("mid_rst_dtack", dtack_n, 1'b1);
    check("mid_rst_flip", bcu_flip, 1'b0);
    check("mid_rst_scroll", layer_scroll, 128'h0);
    cs_v = 5'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    access(CS_ATTR, 1'b0, 3'd0, 16'h7777, lat, din);
    check("post_rst_lat", lat, 2);
    check("post_rst_addr", we_addr, 13'h0000);
    check("post_rst_data", we_data, 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
